// File: rtl/fizzbuzz_gen_multi.sv
// Multi-channel divisibility sequence generator: streams 1..g_length with one
// hit flag per programmable divisor, tracked by incremental residue counters.

module fizzbuzz_gen_multi_lane #(
  parameter int              W       = 8,
  parameter logic [W-1:0]    DEFAULT = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_we,
  input  logic [W-1:0] i_wdata,
  input  logic         i_init,
  input  logic         i_adv,
  output logic         o_hit
);
  logic [W-1:0] div_q, res_q, div_eff;

  // A write coinciding with start must already govern the initial residue.
  assign div_eff = i_we ? i_wdata : div_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= DEFAULT;
      res_q <= W'(1);
    end else begin
      if (i_we) div_q <= i_wdata;
      if (i_init)
        res_q <= (div_eff == W'(1)) ? '0 : W'(1);
      else if (i_adv)
        res_q <= (res_q == div_q - W'(1)) ? '0 : res_q + W'(1);
    end
  end

  assign o_hit = (res_q == '0) && (div_q != '0);
endmodule

module fizzbuzz_gen_multi #(
  parameter int g_length    = 20,
  parameter int g_channels  = 3,
  parameter int g_div_width = 8,
  parameter int g_wrap      = 0,
  localparam int IDX_W = (g_channels > 1) ? $clog2(g_channels) : 1,
  localparam int NW    = $clog2(g_length + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_start,
  input  logic                   i_cfg_we,
  input  logic [IDX_W-1:0]       i_cfg_idx,
  input  logic [g_div_width-1:0] i_cfg_div,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [NW-1:0]          o_number,
  output logic [g_channels-1:0]  o_hits,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_wrap
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam bit WRAP = (g_wrap != 0);

  state_t                state_q;
  logic                  valid_q, done_q, wrap_q;
  logic [NW-1:0]         num_q;
  logic [g_channels-1:0] hit;
  logic                  idle_or_done, cfg_go, start_go, xfer, last, adv, init;

  assign idle_or_done = (state_q != S_RUN);
  assign cfg_go       = i_en & i_cfg_we & idle_or_done;
  assign start_go     = i_en & i_start & idle_or_done;
  assign xfer         = i_en & valid_q & i_ready;
  assign last         = (num_q == NW'(g_length));
  assign adv          = xfer & ~last;
  assign init         = start_go | (xfer & last & WRAP);

  // Out-of-range indices match no lane, so they are dropped naturally.
  for (genvar k = 0; k < g_channels; k++) begin : g_lane
    fizzbuzz_gen_multi_lane #(
      .W       (g_div_width),
      .DEFAULT (g_div_width'(3 + 2 * k))
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (cfg_go && (i_cfg_idx == IDX_W'(k))),
      .i_wdata (i_cfg_div),
      .i_init  (init),
      .i_adv   (adv),
      .o_hit   (hit[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      num_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (i_en) begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              state_q <= S_RUN;
              valid_q <= 1'b1;
              num_q   <= NW'(1);
            end
          end
          S_RUN: begin
            if (valid_q && i_ready) begin
              if (!last) begin
                num_q <= num_q + NW'(1);
              end else if (WRAP) begin
                num_q  <= NW'(1);
                wrap_q <= 1'b1;
              end else begin
                state_q <= S_DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_valid  = valid_q;
  assign o_number = num_q;
  assign o_hits   = valid_q ? hit : '0;
  assign o_busy   = (state_q == S_RUN);
  assign o_done   = done_q;
  assign o_wrap   = wrap_q;
endmodule

// File: tb/tb_fizzbuzz_gen_multi.sv
// Self-checking bench: randomized handshake and divisors against a modulo-based
// reference model; a second instance covers wrap-around mode.

module tb_fizzbuzz_gen_multi;
  localparam int LEN = 20, NCH = 3, DW = 8, WLEN = 6;

  logic          clk = 1'b0;
  logic          rst, en, start, cfg_we, ready;
  logic [1:0]    cfg_idx;
  logic [DW-1:0] cfg_div;
  logic          valid, busy, done, wrap;
  logic [4:0]    number;
  logic [NCH-1:0] hits;

  logic          w_start, w_ready, w_valid, w_busy, w_done, w_wrap;
  logic [2:0]    w_number;
  logic [NCH-1:0] w_hits;

  int checks = 0, errors = 0;
  int div_m [NCH];
  int def_m [NCH];

  always #5 clk = ~clk;

  fizzbuzz_gen_multi #(.g_length(LEN), .g_channels(NCH), .g_div_width(DW), .g_wrap(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start), .i_cfg_we(cfg_we),
    .i_cfg_idx(cfg_idx), .i_cfg_div(cfg_div), .i_ready(ready), .o_valid(valid),
    .o_number(number), .o_hits(hits), .o_busy(busy), .o_done(done), .o_wrap(wrap));

  fizzbuzz_gen_multi #(.g_length(WLEN), .g_channels(NCH), .g_div_width(DW), .g_wrap(1)) dutw (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(w_start), .i_cfg_we(1'b0),
    .i_cfg_idx(2'd0), .i_cfg_div(8'd0), .i_ready(w_ready), .o_valid(w_valid),
    .o_number(w_number), .o_hits(w_hits), .o_busy(w_busy), .o_done(w_done), .o_wrap(w_wrap));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] model_hits(input int n, input int d [NCH]);
    logic [NCH-1:0] h;
    for (int k = 0; k < NCH; k++) h[k] = (d[k] != 0) && (n % d[k] == 0);
    return h;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int idx, input int val, input bit with_start);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_div = val[DW-1:0]; start = with_start;
    if (idx < NCH) div_m[idx] = val;
    tick();
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // mode 0: ready=1, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_stream(input int mode, input bit try_cfg, input bit en_gap, input int stop_at);
    int  exp_n = 1, cyc = 0;
    bit  fin = 0, xfer;
    bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (!fin && cyc < 300) begin
      chk("busy", busy, 1);
      chk("valid", valid, 1);
      chk("done_lo", done, 0);
      chk("wrap_lo", wrap, 0);
      chk("number", number, exp_n);
      chk("hits", hits, model_hits(exp_n, div_m));
      if (stop_at != 0 && exp_n == stop_at) begin
        ready = 1'b0;
        break;
      end
      en = !(en_gap && cyc >= 5 && cyc < 10);
      case (mode)
        0: ready = 1'b1;
        1: ready = pat[cyc % 4];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      cfg_we = try_cfg && cyc == 3; cfg_idx = 2'd0; cfg_div = 8'd9;
      xfer = ready && en;
      tick();
      cyc++;
      cfg_we = 1'b0; en = 1'b1;
      if (xfer) begin
        if (exp_n == LEN) begin
          fin = 1;
          chk("done_pulse", done, 1);
          chk("valid_end", valid, 0);
          chk("busy_end", busy, 0);
          chk("number_end", number, LEN);
        end else exp_n++;
      end
    end
    if (stop_at == 0) begin
      chk("stream_complete", fin, 1);
      if (mode == 0 && !en_gap) chk("throughput", cyc, LEN);
      tick();
      chk("done_one_cycle", done, 0);
      chk("valid_after", valid, 0);
    end
  endtask

  initial begin
    int exp_w, xf, cyc;
    bit exp_wrap, x;
    for (int k = 0; k < NCH; k++) begin def_m[k] = 3 + 2 * k; div_m[k] = def_m[k]; end
    rst = 1; en = 1; start = 0; cfg_we = 0; cfg_idx = 0; cfg_div = 0; ready = 0;
    w_start = 0; w_ready = 0;
    tick(); tick();
    chk("rst_valid", valid, 0); chk("rst_number", number, 0); chk("rst_hits", hits, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);     chk("rst_wrap", wrap, 0);
    rst = 0;
    tick();
    chk("idle_valid", valid, 0);

    do_start();
    run_stream(0, 0, 0, 0);
    do_start();
    run_stream(1, 0, 0, 0);
    do_start();
    run_stream(2, 0, 0, 0);

    // Config in idle; last write shares the cycle with start; a RUN write is ignored.
    cfg_write(0, 4, 0);
    cfg_write(1, 1, 0);
    cfg_write(3, 2, 0);
    cfg_write(2, 0, 1);
    run_stream(2, 1, 0, 0);

    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < NCH; k++) cfg_write(k, $urandom_range(0, 12), 0);
      do_start();
      run_stream(2, 0, 0, 0);
    end

    do_start();
    run_stream(0, 0, 1, 0);

    // Reset while stalled at 11 restores defaults.
    do_start();
    run_stream(0, 0, 0, 11);
    tick();
    chk("stall_number", number, 11);
    chk("stall_hits", hits, model_hits(11, div_m));
    rst = 1; tick(); rst = 0;
    chk("mid_rst_valid", valid, 0); chk("mid_rst_number", number, 0);
    chk("mid_rst_hits", hits, 0);   chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int k = 0; k < NCH; k++) div_m[k] = def_m[k];
    do_start();
    run_stream(2, 0, 0, 0);

    // Wrap-mode instance.
    w_start = 1; tick(); w_start = 0;
    exp_w = 1; xf = 0; cyc = 0; exp_wrap = 0;
    while (xf < 2 * WLEN && cyc < 100) begin
      chk("w_valid", w_valid, 1);
      chk("w_busy", w_busy, 1);
      chk("w_done", w_done, 0);
      chk("w_number", w_number, exp_w);
      chk("w_hits", w_hits, model_hits(exp_w, def_m));
      chk("w_wrap", w_wrap, exp_wrap);
      w_ready = 1'($urandom_range(0, 1));
      x = w_ready;
      tick();
      cyc++;
      exp_wrap = 0;
      if (x) begin
        xf++;
        if (exp_w == WLEN) begin exp_w = 1; exp_wrap = 1; end
        else exp_w++;
      end
    end
    chk("w_complete", xf, 2 * WLEN);
    chk("w_wrap_final", w_wrap, 1);
    chk("w_number_final", w_number, 1);
    w_ready = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fizzbuzz_gen_multi.md
Name: fizzbuzz_gen_multi

Overview:
Parametrised successor to the single-fizz/buzz counter. It generates the sequence 1..g_length on a valid/ready output stream. Each output word carries g_channels divisibility flags, one per runtime-programmable divisor. It adds optional wrap-around mode, backpressure, a done pulse, and divide-free residue tracking. It sits between the sequence controller and downstream consumers/checkers.

Parameters:
g_length, 20, last number emitted; legal range 1..2^16-1
g_channels, 3, number of divisor channels; legal range 1..8
g_div_width, 8, width of each divisor register
g_wrap, 0, 0 = stop after g_length; 1 = restart at 1 after g_length

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_en  in  1  global enable; 0 freezes all state except reset
i_start  in  1  start request; honoured only in IDLE or DONE
i_cfg_we  in  1  divisor write strobe; honoured only in IDLE or DONE
i_cfg_idx  in  $clog2(g_channels) (min 1)  divisor index to write
i_cfg_div  in  g_div_width  divisor value
i_ready  in  1  downstream ready
o_valid  out  1  output word valid
o_number  out  $clog2(g_length+1)  current number
o_hits  out  g_channels  bit k = (o_number mod div_k == 0)
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse after the final transfer (g_wrap=0)
o_wrap  out  1  one-cycle pulse when the sequence restarts (g_wrap=1)

Behaviour:
- Reset: state=IDLE; o_valid=0, o_number=0, o_hits=0, o_busy=0, o_done=0, o_wrap=0; divisor k = 3+2k (3,5,7,...).
- States: IDLE, RUN, DONE. The clock and reset are single-domain; the reset is synchronous and active-high on i_rst.
- i_en=0: no state, counter, residue or config change. The o_done/o_wrap pulses are not extended. Outputs hold.
- IDLE/DONE with i_en & i_start: next cycle state=RUN, o_valid=1, o_number=1, residues initialised to 1 mod div_k.
- Latency from start to first valid word: 1 cycle.
- Config: i_cfg_we & i_en in IDLE/DONE writes div[i_cfg_idx]. Writes in RUN are ignored. An out-of-range index is ignored. If i_cfg_we and i_start occur in the same cycle, the write takes effect first, so the new divisor applies to the run.
- Handshake: a transfer occurs when o_valid & i_ready & i_en.
  - While o_valid=1 and no transfer, o_number and o_hits are stable.
  - Throughput is one word per cycle with i_ready held high.
- Advance on transfer with o_number < g_length: o_number+1; residue_k := (residue_k == div_k-1) ? 0 : residue_k+1.
- Final transfer (o_number == g_length):
  - g_wrap=0: next cycle o_valid=0, o_busy=0, state=DONE, o_done=1 for exactly one cycle. o_number keeps g_length.
  - g_wrap=1: next cycle o_number=1, residues reinitialised, o_wrap=1 for one cycle, o_valid stays 1, state stays RUN.
- Hits are combinational from registered state: hit_k = (residue_k == 0) & (div_k != 0).
  - div_k = 0 never hits.
  - div_k = 1 always hits; residue is held at 0.
- No divider or modulo operator in RTL; residues are incremental counters of width g_div_width.
- o_number never exceeds g_length and never wraps through 2^width.
- i_start in RUN is ignored; there is no abort. Only i_rst terminates a run.
- Reset mid-run (including with o_valid=1 and i_ready=0): all outputs take reset values on the next edge. Divisors revert to defaults.
- g_length=1: a single word (1, hits for divisors 1 only) is emitted, then DONE (or wrap every transfer).

Test Plan:
- Defaults, i_ready=1, g_length=20: start → 20 consecutive words 1..20. Hits[0] at 3,6,9,12,15,18; hits[1] at 5,10,15,20; hits[2] at 7,14. o_done one cycle after 20; o_valid=0 afterwards.
- Backpressure: i_ready toggles 1,0,0,1 pattern → no word dropped or duplicated; o_number/o_hits stable while stalled; order 1..20 preserved.
- Config: write div0=4, div1=1, div2=0 in IDLE, then start → hits[0] at 4,8,12,16,20; hits[1] on every word; hits[2] never. A write attempted during RUN has no effect.
- g_wrap=1, g_length=6: sequence 1..6,1..6; o_wrap pulse coincides with the second "1"; hits[0] correct across the boundary (3,6,3,6).
- i_en low for 5 cycles mid-run while i_ready=1 → no advance, no transfer; resumes at the same number.
- i_rst asserted at o_number=11 with stall → next cycle all outputs 0, state IDLE, div0 back to 3. A restart emits from 1.
